// File: rtl/top_stage.sv
// Single-cycle RISC-V fetch/decode stage: free-running PC, 64-word instruction ROM,
// immediate generator, 32x32 register file and main/ALU control decoders.
module top_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  func3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  func7,
    output logic [31:0] imm,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_control
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    alu_ctrl_e   alu_ctrl;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d = pc_q + 32'd4;
    end

    always_comb begin
        regs_d = regs_q;
        if (we && (rd != 5'd0)) begin
            regs_d[rd] = wd;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            // NOTE: the register file is a flop array, not a RAM, so it can and must clear on reset.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
        end
    end

    assign pc = pc_q;

    always_comb begin
        instr = 32'h0000_0013;
        case (pc_q[7:2])
            6'd0:    instr = 32'h0050_0093;
            6'd1:    instr = 32'h0020_81B3;
            6'd2:    instr = 32'h0080_A203;
            6'd3:    instr = 32'h0040_A623;
            6'd4:    instr = 32'h0020_8863;
            default: instr = 32'h0000_0013;
        endcase
    end

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign func3  = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign func7  = instr[31:25];

    always_comb begin
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm = {{19{instr[31]}}, instr[31], instr[7],
                                             instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {instr[31:12], 12'b0};
            OP_JAL:                   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                             instr[20], instr[30:21], 1'b0};
            default:                  imm = '0;
        endcase
    end

    // x0 is forced to zero at the read port; writes into it are already blocked above.
    assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    always_comb begin
        alu_op = 2'b00;
        case (opcode)
            OP_BRANCH: alu_op = 2'b01;
            OP_REG:    alu_op = 2'b10;
            OP_IMM:    alu_op = 2'b11;
            default:   alu_op = 2'b00;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            default: begin
                case (func3)
                    3'b000:  alu_ctrl = (alu_op == 2'b10 && func7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

    assign alu_control = alu_ctrl;

endmodule

// File: tb/tb_top_stage.sv
// Directed bench for top_stage: fetch sequence, decode fields, register-file writes,
// x0 protection and mid-program reset; outputs are sampled on the falling edge.
module tb_top_stage;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] wd;
    logic [31:0] pc, instr, imm, rd1, rd2;
    logic [6:0]  opcode, func7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [1:0]  alu_op;
    logic [3:0]  alu_control;

    int checks   = 0;
    int failures = 0;

    top_stage dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .wd          (wd),
        .pc          (pc),
        .instr       (instr),
        .opcode      (opcode),
        .rd          (rd),
        .func3       (func3),
        .rs1         (rs1),
        .rs2         (rs2),
        .func7       (func7),
        .imm         (imm),
        .rd1         (rd1),
        .rd2         (rd2),
        .alu_op      (alu_op),
        .alu_control (alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle to the falling edge where outputs are compared.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wd    = '0;
        @(negedge clk);
        step();

        check("rst_pc",          pc,                 32'd0);
        check("rst_instr",       instr,              32'h0050_0093);
        check("rst_opcode",      {25'd0, opcode},    32'h13);
        check("rst_rd",          {27'd0, rd},        32'd1);
        check("rst_rs1",         {27'd0, rs1},       32'd0);
        check("rst_imm",         imm,                32'd5);
        check("rst_alu_op",      {30'd0, alu_op},    32'd3);
        check("rst_alu_control", {28'd0, alu_control}, 32'b0010);
        check("rst_rd1",         rd1,                32'd0);

        // Write x1=17 on the edge leaving pc=0.
        reset = 1'b0;
        we    = 1'b1;
        wd    = 32'd17;
        step();
        we = 1'b0;
        check("pc4_pc",          pc,                 32'd4);
        check("pc4_instr",       instr,              32'h0020_81B3);
        check("pc4_opcode",      {25'd0, opcode},    32'h33);
        check("pc4_rd",          {27'd0, rd},        32'd3);
        check("pc4_func3",       {29'd0, func3},     32'd0);
        check("pc4_rs1",         {27'd0, rs1},       32'd1);
        check("pc4_rs2",         {27'd0, rs2},       32'd2);
        check("pc4_func7",       {25'd0, func7},     32'd0);
        check("pc4_imm",         imm,                32'd0);
        check("pc4_alu_op",      {30'd0, alu_op},    32'd2);
        check("pc4_alu_control", {28'd0, alu_control}, 32'b0010);
        check("pc4_rd1",         rd1,                32'd17);
        check("pc4_rd2",         rd2,                32'd0);

        step();
        check("pc8_pc",          pc,                 32'd8);
        check("pc8_instr",       instr,              32'h0080_A203);
        check("pc8_imm",         imm,                32'd8);
        check("pc8_alu_op",      {30'd0, alu_op},    32'd0);
        check("pc8_alu_control", {28'd0, alu_control}, 32'b0010);
        check("pc8_rd1",         rd1,                32'd17);

        // lw x4 is the current instruction: write x4=0xAB, read back via sw's rs2=4.
        we = 1'b1;
        wd = 32'h0000_00AB;
        check("pc8_rd1_during_we", rd1,              32'd17);
        step();
        we = 1'b0;
        check("pc12_pc",         pc,                 32'd12);
        check("pc12_instr",      instr,              32'h0040_A623);
        check("pc12_imm",        imm,                32'd12);
        check("pc12_rs2",        {27'd0, rs2},       32'd4);
        check("pc12_rd2",        rd2,                32'h0000_00AB);
        check("pc12_rd1",        rd1,                32'd17);

        step();
        check("pc16_pc",          pc,                32'd16);
        check("pc16_instr",       instr,             32'h0020_8863);
        check("pc16_imm",         imm,               32'd16);
        check("pc16_alu_op",      {30'd0, alu_op},   32'd1);
        check("pc16_alu_control", {28'd0, alu_control}, 32'b0110);

        step();
        check("pc20_pc",         pc,                 32'd20);
        check("pc20_instr",      instr,              32'h0000_0013);
        check("pc20_rd",         {27'd0, rd},        32'd0);

        // Attempt to write x0 via the nop's rd=0.
        we = 1'b1;
        wd = 32'hFFFF_FFFF;
        step();
        we = 1'b0;
        check("pc24_pc",         pc,                 32'd24);
        check("x0_rd1",          rd1,                32'd0);
        check("x0_rd2",          rd2,                32'd0);

        step();
        check("pc28_pc",         pc,                 32'd28);

        // Mid-program reset with a competing write request.
        reset = 1'b1;
        we    = 1'b1;
        wd    = 32'd17;
        step();
        check("mid_rst_pc",      pc,                 32'd0);
        // Second reset edge at pc=0 (rd=1): write must still be blocked.
        step();
        check("mid_rst_pc_hold", pc,                 32'd0);
        check("mid_rst_instr",   instr,              32'h0050_0093);

        reset = 1'b0;
        we    = 1'b0;
        step();
        check("restart_pc4",     pc,                 32'd4);
        check("restart_x1",      rd1,                32'd0);
        step();
        check("restart_pc8",     pc,                 32'd8);
        step();
        check("restart_pc12",    pc,                 32'd12);
        check("restart_x4",      rd2,                32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_stage.md
TOP_STAGE -- requirements
Module: top_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: we  in  1  register-file write enable.
REQ-004 SHALL have ports: wd  in  32  register-file write data.
REQ-005 SHALL have outputs: pc 32 current PC; instr 32 fetched word; opcode 7 = instr[6:0]; rd 5 = instr[11:7]; func3 3 = instr[14:12]; rs1 5 = instr[19:15]; rs2 5 = instr[24:20]; func7 7 = instr[31:25].
REQ-006 SHALL have outputs: imm 32 sign-extended immediate; rd1 32 = x[rs1]; rd2 32 = x[rs2]; alu_op 2; alu_control 4.
REQ-007 SHALL use one clock (clk); reset is synchronous and active-high; no parameters.

Function
REQ-008 PC register SHALL load 0 on reset and otherwise pc+4 at every rising edge, wrapping modulo 2^32.
REQ-009 Instruction ROM SHALL be 64x32, combinational, indexed by pc[7:2]; instr SHALL follow pc in the same cycle.
REQ-010 ROM contents SHALL be: [0]=0x00500093 (addi x1,x0,5); [1]=0x002081B3 (add x3,x1,x2); [2]=0x0080A203 (lw x4,8(x1)); [3]=0x0040A623 (sw x4,12(x1)); [4]=0x00208863 (beq x1,x2,16); [5..63]=0x00000013 (nop).
REQ-011 Field outputs SHALL be pure combinational slices of instr.
REQ-012 imm SHALL be: I-type (opcode 0x13,0x03,0x67) sext(instr[31:20]); S (0x23) sext({instr[31:25],instr[11:7]}); B (0x63) sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U (0x37,0x17) {instr[31:12],12'b0}; J (0x6F) sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); any other opcode 0.
REQ-013 Register file SHALL hold 32x32 registers; reads rd1/rd2 combinational and asynchronous to the write port.
REQ-014 Write SHALL occur at rising edge when we=1, reset=0 and rd!=0: x[rd] <= wd, rd taken from the current instr.
REQ-015 x0 SHALL always read 0; writes to x0 ignored.
REQ-016 Read during write to the same register SHALL return the old value until the edge (no bypass).
REQ-017 alu_op SHALL be: 00 for 0x03/0x23/0x17/0x37/0x67/0x6F; 01 for 0x63; 10 for 0x33; 11 for 0x13; 00 for unknown.
REQ-018 alu_control encoding SHALL be: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.
REQ-019 alu_op 00 SHALL give ADD; 01 SHALL give SUB.
REQ-020 alu_op 10/11 SHALL decode func3: 000 ADD (SUB if alu_op=10 and func7[5]=1); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if func7[5]=1 else SRL; 110 OR; 111 AND.

Reset
REQ-021 While reset=1 at an edge, pc SHALL become 0 and all 32 registers SHALL become 0; reset SHALL override a simultaneous we=1.
REQ-022 Reset mid-program SHALL restart fetch at ROM[0] in the cycle after the edge; before the first edge outputs are undefined.
REQ-023 All decode outputs SHALL be combinational from pc/instr/register state, so after reset they SHALL show ROM[0] decode: opcode 0x13, rd 1, rs1 0, imm 5, alu_op 11, alu_control 0010, rd1 0.

Verification
REQ-024 Reset one edge, then free-run -> pc 0,4,8,12,16,20; instr 0x00500093, 0x002081B3, 0x0080A203, 0x0040A623, 0x00208863, 0x00000013.
REQ-025 At pc=4 -> opcode 0x33, rd 3, rs1 1, rs2 2, imm 0, alu_op 10, alu_control 0010; at pc=8 -> imm 8, alu_op 00; at pc=12 -> imm 12; at pc=16 -> imm 16, alu_op 01, alu_control 0110.
REQ-026 After reset, we=1, wd=17 for the edge at pc=0 (rd=1) -> at pc=4 rd1=17, rd2=0; at pc=8 rd1=17.
REQ-027 we=1, wd=0xFFFFFFFF while instr rd=0 (force via ROM nop at pc=20) -> x0 still reads 0.
REQ-028 Assert reset with we=1, wd=17 at pc=0 -> registers stay 0, pc stays 0; deassert -> sequence restarts from 0.
